// File: rtl/ni_flit_injector.sv
// ni_flit_injector: network-interface transmit stage feeding a router LOCAL port.
// Builds packets as target flit, size flit, then payload flits. Payload words come
// from an internal FIFO, so the core can write ahead of router back-pressure.
// Optional build macro NI_CHECKSUM_EN: appends one XOR checksum flit after the
// payload, and the size flit then counts that flit too.
module ni_flit_injector #(
    parameter int TAM_FLIT   = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_SIZE   = 255
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic [TAM_FLIT-1:0]           i_target,
    input  logic [TAM_FLIT-1:0]           i_size,
    input  logic                          i_wr,
    input  logic [TAM_FLIT-1:0]           i_wdata,
    output logic                          o_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_err,
    input  logic                          i_credit,
    output logic                          o_tx,
    output logic [TAM_FLIT-1:0]           o_data,
    output logic                          o_clk_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [TAM_FLIT:0] MAX_SIZE_V = MAX_SIZE[TAM_FLIT:0];

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_SIZE, S_PAYLOAD, S_CHK} state_t;

    state_t              state;
    logic [TAM_FLIT-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       rd_ptr_inc;
    logic [LW-1:0]       count;
    logic [TAM_FLIT-1:0] size_flit;
    logic [TAM_FLIT-1:0] remaining;
    logic [TAM_FLIT:0]   size_eff;
    logic                size_ok;
    logic                accept;
    logic                push;
    logic                pop;
`ifdef NI_CHECKSUM_EN
    logic [TAM_FLIT-1:0] chk;
`endif

    assign o_clk_tx   = i_clk;
    assign o_full     = (count == LW'(FIFO_DEPTH));
    assign o_level    = count;
    assign o_busy     = (state != S_IDLE);
    assign accept     = o_tx & i_credit;
    assign push       = i_wr & ~o_full;
    assign pop        = (state == S_PAYLOAD) & accept;
    assign rd_ptr_inc = rd_ptr + 1'b1;

    // Size flit value and legality check for the incoming request.
    always_comb begin
`ifdef NI_CHECKSUM_EN
        size_eff = {1'b0, i_size} + 1'b1;
`else
        size_eff = {1'b0, i_size};
`endif
        size_ok = (i_size != '0) && (size_eff <= MAX_SIZE_V);
    end

    // Payload storage; writes only land in free slots, so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_wdata;
        end
    end

    // FIFO pointers and occupancy; a write into a full FIFO is dropped even if a pop happens.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr_inc;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Packet FSM with registered flit outputs; o_data holds until the router accepts it.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= S_IDLE;
            o_tx      <= 1'b0;
            o_data    <= '0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            size_flit <= '0;
            remaining <= '0;
`ifdef NI_CHECKSUM_EN
            chk       <= '0;
`endif
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        if (size_ok) begin
                            o_data    <= i_target;
                            o_tx      <= 1'b1;
                            size_flit <= size_eff[TAM_FLIT-1:0];
                            remaining <= i_size;
`ifdef NI_CHECKSUM_EN
                            chk       <= '0;
`endif
                            state     <= S_HDR;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        o_data <= size_flit;
                        state  <= S_SIZE;
                    end
                end
                S_SIZE: begin
                    if (accept) begin
                        state <= S_PAYLOAD;
                        // Stage the FIFO head straight away so payload follows without a gap.
                        if (count != '0) begin
                            o_data <= mem[rd_ptr];
                            o_tx   <= 1'b1;
                        end else begin
                            o_tx <= 1'b0;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (accept) begin
                        remaining <= remaining - 1'b1;
`ifdef NI_CHECKSUM_EN
                        chk <= chk ^ o_data;
`endif
                        if (remaining == TAM_FLIT'(1)) begin
`ifdef NI_CHECKSUM_EN
                            o_data <= chk ^ o_data;
                            o_tx   <= 1'b1;
                            state  <= S_CHK;
`else
                            o_tx   <= 1'b0;
                            o_done <= 1'b1;
                            state  <= S_IDLE;
`endif
                        end else if (count > LW'(1)) begin
                            // Next word is already stored behind the one being popped.
                            o_data <= mem[rd_ptr_inc];
                        end else begin
                            o_tx <= 1'b0;
                        end
                    end else if (!o_tx && count != '0) begin
                        o_data <= mem[rd_ptr];
                        o_tx   <= 1'b1;
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        o_tx   <= 1'b0;
                        o_done <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    o_tx  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ni_flit_injector.sv
// Testbench for ni_flit_injector: directed steps with a flit scoreboard.
// The bench uses its own model FIFO, so a write into a full FIFO is dropped there too.
// An expected flit is queued once its payload word and its packet are both known.
// The monitor compares each flit the router accepts against the head of that queue.
module tb_ni_flit_injector;
    localparam int W = 16;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b0;
    logic         i_start = 1'b0;
    logic [W-1:0] i_target = '0;
    logic [W-1:0] i_size = '0;
    logic         i_wr = 1'b0;
    logic [W-1:0] i_wdata = '0;
    logic         o_full;
    logic [3:0]   o_level;
    logic         o_busy;
    logic         o_done;
    logic         o_err;
    logic         i_credit = 1'b1;
    logic         o_tx;
    logic [W-1:0] o_data;
    logic         o_clk_tx;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_q[$];
    int           pkt_left = 0;
    logic [W-1:0] chk_acc = '0;
    logic         held_valid = 1'b0;
    logic [W-1:0] held_data = '0;

    ni_flit_injector #(.TAM_FLIT(W), .FIFO_DEPTH(8), .MAX_SIZE(255)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_target(i_target),
        .i_size(i_size), .i_wr(i_wr), .i_wdata(i_wdata), .o_full(o_full),
        .o_level(o_level), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .i_credit(i_credit), .o_tx(o_tx), .o_data(o_data), .o_clk_tx(o_clk_tx)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move model FIFO words into the expected-flit queue while the packet still needs them.
    task automatic flush_expect();
        while (pkt_left > 0 && model_q.size() > 0) begin
            logic [W-1:0] w;
            w = model_q.pop_front();
            chk_acc ^= w;
            exp_q.push_back(w);
            pkt_left--;
`ifdef NI_CHECKSUM_EN
            if (pkt_left == 0) exp_q.push_back(chk_acc);
`endif
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic write_word(input logic [W-1:0] w);
        i_wr = 1'b1;
        i_wdata = w;
        if (model_q.size() < 8) model_q.push_back(w);
        tick();
        i_wr = 1'b0;
        flush_expect();
    endtask

    task automatic start_pkt(input logic [W-1:0] tgt, input logic [W-1:0] sz);
        i_start = 1'b1;
        i_target = tgt;
        i_size = sz;
        exp_q.push_back(tgt);
`ifdef NI_CHECKSUM_EN
        exp_q.push_back(sz + 16'd1);
`else
        exp_q.push_back(sz);
`endif
        pkt_left = int'(sz);
        chk_acc = '0;
        flush_expect();
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
        check({tag, "_drain"}, exp_q.size(), 32'd0);
    endtask

    // Compare each accepted flit, and check that a flit under back-pressure does not change.
    always @(negedge i_clk) begin
        if (i_rst && o_tx) begin
            if (held_valid) check("hold_stable", o_data, held_data);
            if (i_credit) begin
                vectors++;
                assert (exp_q.size() > 0) else begin
                    miscompares++;
                    $error("FAIL extra_flit: observed %0h expected none", o_data);
                end
                if (exp_q.size() > 0) begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    check("flit", o_data, e);
                    $display("flit %h expected %h", o_data, e);
                end
                held_valid = 1'b0;
            end else begin
                held_valid = 1'b1;
                held_data = o_data;
            end
        end else begin
            held_valid = 1'b0;
        end
    end

    initial begin
        logic pat[4];
        bit   seen;
        int   nflits;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state
        #2;
        check("rst_tx", o_tx, 0);
        check("rst_data", o_data, 0);
        check("rst_full", o_full, 0);
        check("rst_level", o_level, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        tick();
        i_rst = 1'b1;
        tick();

        // Back-to-back packet with a preloaded FIFO
        write_word(16'h0011);
        write_word(16'h0022);
        write_word(16'h0033);
        check("t1_level", o_level, model_q.size());
        start_pkt(16'h0102, 16'd3);
        check("t1_busy", o_busy, 1);
`ifdef NI_CHECKSUM_EN
        nflits = 6;
`else
        nflits = 5;
`endif
        for (int k = 0; k < nflits; k++) begin
            check("t1_tx_consec", o_tx, 1);
            tick();
        end
        check("t1_done", o_done, 1);
        check("t1_tx_after", o_tx, 0);
        check("t1_busy_after", o_busy, 0);
        check("t1_drain", exp_q.size(), 0);
        tick();
        check("t1_done_pulse", o_done, 0);

        // Same packet under credit toggling
        write_word(16'h0011);
        write_word(16'h0022);
        write_word(16'h0033);
        start_pkt(16'h0102, 16'd3);
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            i_credit = pat[k % 4];
            tick();
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        i_credit = 1'b1;
        check("t2_done", 32'(seen), 1);
        check("t2_drain", exp_q.size(), 0);
        tick();

        // Empty FIFO: bubbles until words arrive; a start while busy is ignored
        start_pkt(16'h0201, 16'd2);
        repeat (4) tick();
        i_start = 1'b1;
        i_target = 16'h0999;
        i_size = 16'd5;
        tick();
        i_start = 1'b0;
        repeat (5) tick();
        check("t3_bubble_tx", o_tx, 0);
        check("t3_busy", o_busy, 1);
        write_word(16'hAAAA);
        write_word(16'hBBBB);
        wait_done("t3", 50);
        tick();
        check("t3_idle_tx", o_tx, 0);

        // Illegal sizes are rejected
        i_start = 1'b1;
        i_size = 16'd0;
        i_target = 16'h0505;
        tick();
        i_start = 1'b0;
        check("t4_err_size0", o_err, 1);
        check("t4_busy_size0", o_busy, 0);
        check("t4_tx_size0", o_tx, 0);
        tick();
        check("t4_err_pulse", o_err, 0);
        i_start = 1'b1;
        i_size = 16'h0100;
        tick();
        i_start = 1'b0;
        check("t4_err_size256", o_err, 1);
        check("t4_busy_size256", o_busy, 0);
        check("t4_tx_size256", o_tx, 0);
        tick();

        // Overfill: the 9th write is dropped
        i_wr = 1'b1;
        for (int k = 0; k < 9; k++) begin
            i_wdata = 16'h0100 + 16'(k);
            if (model_q.size() < 8) model_q.push_back(i_wdata);
            tick();
        end
        i_wr = 1'b0;
        check("t5_full", o_full, 1);
        check("t5_level", o_level, 8);
        start_pkt(16'h0303, 16'd8);
        wait_done("t5", 50);
        check("t5_level_after", o_level, 0);
        check("t5_full_after", o_full, 0);

        // Reset during the second payload flit of four, then a fresh packet
        for (int k = 0; k < 4; k++) write_word(16'hC000 + 16'(k));
        start_pkt(16'h0404, 16'd4);
        repeat (3) tick();
        i_rst = 1'b0;
        #1;
        check("t6_rst_tx", o_tx, 0);
        check("t6_rst_level", o_level, 0);
        check("t6_rst_busy", o_busy, 0);
        exp_q.delete();
        model_q.delete();
        pkt_left = 0;
        tick();
        i_rst = 1'b1;
        tick();
        check("t6_post_tx", o_tx, 0);
        write_word(16'h5A5A);
        start_pkt(16'h0304, 16'd1);
        wait_done("t6", 30);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ni_flit_injector.md
Name: ni_flit_injector

Overview:
Network-interface transmit stage that sits directly upstream of the router's LOCAL input port. It packetizes core messages into the Phoenix/Hermes flit format (target flit, size flit, payload flits) and drives the router local rx/data/credit handshake. Payload words are buffered in an internal FIFO so the core can write ahead of router back-pressure.

Parameters:
TAM_FLIT, 16, flit width in bits
FIFO_DEPTH, 8, payload FIFO entries; power of 2, >=2
MAX_SIZE, 255, largest legal payload flit count per packet

Ports:
i_clk  input  1  system clock, rising edge
i_rst  input  1  reset, asynchronous, active-low
i_start  input  1  packet request, sampled only in IDLE
i_target  input  TAM_FLIT  destination address (XY), captured with i_start
i_size  input  TAM_FLIT  payload flit count, captured with i_start
i_wr  input  1  payload FIFO write strobe
i_wdata  input  TAM_FLIT  payload word
o_full  output  1  FIFO full
o_level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
o_busy  output  1  FSM not IDLE
o_done  output  1  one-cycle pulse after last flit accepted
o_err  output  1  one-cycle pulse on rejected request
i_credit  input  1  router local buffer can accept a flit
o_tx  output  1  flit valid toward router local i_rx
o_data  output  TAM_FLIT  flit toward router local i_data
o_clk_tx  output  1  equals i_clk

Behaviour:
- Reset (i_rst=0, async): FSM=IDLE, FIFO flushed, o_tx=0, o_data=0, o_full=0, o_level=0, o_busy=0, o_done=0, o_err=0. Reset mid-packet aborts the packet; no partial flits after release.
- Transfer rule: flit accepted at a rising edge where o_tx=1 and i_credit=1. o_data/o_tx registered and held stable until accepted. Max throughput 1 flit/cycle.
- FSM: IDLE -> HDR -> SIZE -> PAYLOAD -> IDLE.
- IDLE: i_start=1 with 1<=i_size<=MAX_SIZE at edge N -> capture target/size, HDR; o_tx=1, o_data=target from cycle N+1. Size 0 or >MAX_SIZE -> o_err pulse cycle N+1, stay IDLE.
- HDR: on accept -> SIZE, o_data=size flit next cycle.
- SIZE: on accept -> PAYLOAD.
- PAYLOAD: o_tx=1 only when a FIFO word is staged; FIFO empty -> o_tx=0 (bubble), no flit emitted. Remaining-count decrements per accepted payload flit; last accept -> IDLE, o_tx=0 and o_done=1 next cycle.
- i_start while o_busy=1 ignored. New packet earliest: i_start sampled in the cycle o_done=1 (FSM already IDLE).
- FIFO: write when i_wr=1 and o_full=0; write while o_full=1 dropped, even with same-cycle pop. Pop only on payload accept. Simultaneous write+pop when not full: level unchanged. Pointers wrap modulo FIFO_DEPTH. Writes allowed in any state; words beyond current packet stay queued for the next.
- i_credit low indefinitely: outputs frozen, no timeout.

Optional Feature:
NI_CHECKSUM_EN: defined -> extra CHK state after PAYLOAD; emits one flit = XOR of all payload flits; size flit = i_size+1; o_done after CHK accept; MAX_SIZE check uses i_size+1. Undefined -> no CHK state; size flit = i_size.

Test Plan:
- i_credit=1, FIFO preloaded 0x0011,0x0022,0x0033, start target=0x0102 size=3 -> flits 0x0102,0x0003,0x0011,0x0022,0x0033 on 5 consecutive cycles, o_done pulse next cycle (with NI_CHECKSUM_EN: size 0x0004, extra flit 0x0000).
- Same packet, i_credit toggling 1,0,0,1,... -> each flit held stable while i_credit=0, none duplicated/lost, order unchanged.
- Start size=2 with empty FIFO, write words 10 cycles later -> o_tx=0 through PAYLOAD until words arrive, then 2 payload flits, o_done.
- Start size=0 and size=256 -> o_err pulse, o_busy stays 0, o_tx stays 0.
- Write 9 words with FIFO_DEPTH=8, no packet -> o_full=1, o_level=8, 9th word dropped; later size=8 packet emits first 8 words only.
- Assert i_rst=0 during payload flit 2 of 4 -> o_tx=0 immediately, o_level=0; after release new size=1 packet emits correct 3 flits.
